fab_clk_rst_sequencer: RTL and testbench
========================================

Name: fab_clk_rst_sequencer

Overview:
Sequences bring-up of the fabric clock domain driven by the MSS CCC fabric clock (RCOSC-sourced GLA). The CCC lock is not routed to the fabric, so stability is established by a fixed settle count instead. The block then releases per-subsystem resets in a fixed order: PS/2 receiver, then game logic, then video. It also generates a shared clock-enable tick for slow-sampling logic once the domain is running. A software soft-reset request from the MSS re-runs the whole sequence.

Parameters:
STABLE_CYCLES, 1024, clk cycles to wait after reset/lock-ok before the first release; must be >=1
NUM_DOMAINS, 3, number of downstream reset outputs; bit 0 is released first; must be >=1
STAGE_GAP, 16, clk cycles between consecutive releases, and from the last release to ready; must be >=1
TICK_DIV, 100, tick period in clk cycles; must be >=2

Ports:
clk  in  1  fabric clock (CCC FAB_CLK)
rst  in  1  synchronous, active-high reset
ccc_lock  in  1  CCC lock indication; used only when LOCK_MONITOR_EN is defined
soft_rst_req  in  1  software re-sequence request, sampled every cycle; level or pulse
rst_out  out  NUM_DOMAINS  per-domain active-high synchronous resets, registered
ready  out  1  high in RUN, after all domains have been released
tick  out  1  one-cycle clock-enable pulse every TICK_DIV cycles, only in RUN
state_dbg  out  2  current state encoding

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=WAIT, all counters 0, rst_out=all 1s, ready=0, tick=0, state_dbg=WAIT.
- Priority per cycle: rst, then restart (soft_rst_req, or lock loss when the feature is enabled), then normal operation.
- Restart, in any state: on the next edge state=WAIT, counters cleared, rst_out=all 1s, ready=0, tick=0. If soft_rst_req is held high, the block stays in WAIT with the counter held at 0.
- WAIT: wait_cnt increments each cycle while lock_ok. lock_ok is constant 1 without the feature.
  - When wait_cnt==STABLE_CYCLES-1, go to RELEASE. rst_out[0] reads 0 on the same edge.
  - Net effect: after rst falls, rst_out[0] falls exactly STABLE_CYCLES edges later.
- RELEASE: gap_cnt counts 0..STAGE_GAP-1; stage index k starts at 0.
  - On each gap wrap, k increments and rst_out[k] falls.
  - Domain k falls STAGE_GAP*k cycles after domain 0.
  - STAGE_GAP cycles after the last domain falls, go to RUN; ready=1 on that edge.
  - Released bits never re-assert except via restart or rst.
- RUN: ready=1 and rst_out=all 0s.
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick=1 in the cycle where tick_cnt==TICK_DIV-1, so the first tick comes TICK_DIV cycles after RUN entry.
  - tick is never high outside RUN.
- State encoding: WAIT=2'd0, RELEASE=2'd1, RUN=2'd2. 2'd3 is illegal and is treated as WAIT on the next edge.
- Counter widths: $clog2 of the respective parameter, minimum 1. Stage index width: $clog2(NUM_DOMAINS), minimum 1. Counters never exceed their terminal value.

Optional Feature:
Macro: LOCK_MONITOR_EN.
- Defined:
  - ccc_lock passes through a 2-flop synchroniser (reset to 0) to form lock_ok.
  - In WAIT, lock_ok=0 holds wait_cnt at 0.
  - In RELEASE or RUN, lock_ok=0 triggers a restart.
  - Adds 2 cycles of latency from ccc_lock to effect.
- Undefined: ccc_lock is ignored (port kept, unconnected internally) and lock_ok is constant 1.

Decomposition:
- Package fab_clk_pkg: state typedef and the WAIT/RELEASE/RUN encodings; localparam defaults for STABLE_CYCLES, STAGE_GAP and TICK_DIV.
- Sub-module fab_tick_gen(clk, rst, en, tick), parameterised by TICK_DIV, is natural.
  - en=(state==RUN).
  - Counter clears when en=0.
- The sequencer FSM stays in the top module.

Test Plan:
All scenarios use STABLE_CYCLES=8, STAGE_GAP=4, NUM_DOMAINS=3, TICK_DIV=5, with feature off unless stated.
1. Power-up: hold rst 3 cycles, then release. rst_out=111 for 8 cycles, then 110, 4 cycles later 100, 4 later 000, 4 later ready=1 with state_dbg=2.
2. Tick: after ready rises, tick pulses at RUN-relative cycles 5, 10, 15, each exactly 1 cycle wide. tick=0 throughout WAIT and RELEASE.
3. One-cycle soft_rst_req in RUN: next edge rst_out=111, ready=0, tick=0. The full scenario-1 timing then repeats. Holding soft_rst_req for 10 cycles delays the 8-cycle count until it drops.
4. rst asserted while rst_out=100: next edge shows all reset values. Deassert gives scenario-1 timing from scratch.
5. LOCK_MONITOR_EN defined:
   - ccc_lock falls at wait_cnt=5: the count clears, and rst_out[0] falls 8+2 cycles after ccc_lock returns high.
   - ccc_lock falls in RUN: rst_out=111 and ready=0 exactly 3 edges later.
6. Feature undefined: ccc_lock tied 0 or toggling has no effect; timing is identical to scenario 1.

Source files
------------

// File: rtl/fab_clk_pkg.sv
// Shared types and defaults for the fabric clock/reset sequencer.
// Contents: state encoding (WAIT/RELEASE/RUN), default parameter values,
// and a counter-width helper (ceil-log2 with a floor of 1 bit).
package fab_clk_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_NUM_DOMAINS   = 3;
  localparam int unsigned DEF_STAGE_GAP     = 16;
  localparam int unsigned DEF_TICK_DIV      = 100;

  // Bits needed for a counter running 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/fab_tick_gen.sv
// Clock-enable tick generator for slow-sampling logic.
// Ports:
//   clk  in  fabric clock
//   rst  in  synchronous active-high reset
//   en   in  counting enable; counter clears while low
//   tick out registered one-cycle pulse, first one TICK_DIV cycles after en rises,
//            then every TICK_DIV cycles while en stays high
module fab_tick_gen
  import fab_clk_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = cnt_width(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Count 0..TICK_DIV-1; the wrap edge raises tick for exactly one cycle.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/fab_clk_rst_sequencer.sv
// Fabric clock-domain bring-up sequencer. Waits a fixed settle count (the CCC
// lock is not visible to the fabric by default), then releases per-domain
// resets one by one (bit 0 first), then enters RUN with ready and a periodic tick.
// A software soft-reset request re-runs the whole sequence.
// Optional macro LOCK_MONITOR_EN: synchronise ccc_lock and use it to hold the
// settle count in WAIT and to restart on lock loss in RELEASE/RUN.
// Ports:
//   clk           in  fabric clock (CCC FAB_CLK)
//   rst           in  synchronous active-high reset
//   ccc_lock      in  CCC lock (only used with LOCK_MONITOR_EN)
//   soft_rst_req  in  software re-sequence request (level or pulse)
//   rst_out       out per-domain active-high resets, registered
//   ready         out high in RUN after all domains are released
//   tick          out one-cycle clock-enable pulse every TICK_DIV cycles in RUN
//   state_dbg     out current state encoding
module fab_clk_rst_sequencer
  import fab_clk_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned NUM_DOMAINS   = DEF_NUM_DOMAINS,
  parameter int unsigned STAGE_GAP     = DEF_STAGE_GAP,
  parameter int unsigned TICK_DIV      = DEF_TICK_DIV
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ccc_lock,
  input  logic                   soft_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic                   tick,
  output logic [1:0]             state_dbg
);

  localparam int unsigned WAIT_W = cnt_width(STABLE_CYCLES);
  localparam int unsigned GAP_W  = cnt_width(STAGE_GAP);
  localparam int unsigned STG_W  = cnt_width(NUM_DOMAINS);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STABLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(NUM_DOMAINS - 1);

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [STG_W-1:0]       stg_q, stg_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   ready_q, ready_d;

  logic lock_ok_c;
  logic lock_lost_c;
  logic restart_c;
  logic tick_en_c;

`ifdef LOCK_MONITOR_EN
  logic [1:0] lock_sync_q;

  // Two-flop synchroniser; lock is assumed absent until proven after reset.
  always_ff @(posedge clk) begin
    if (rst) lock_sync_q <= 2'b00;
    else     lock_sync_q <= {lock_sync_q[0], ccc_lock};
  end

  assign lock_ok_c   = lock_sync_q[1];
  assign lock_lost_c = ~lock_ok_c & ((state_q == ST_RELEASE) | (state_q == ST_RUN));
`else
  logic unused_ccc_lock;
  assign unused_ccc_lock = ccc_lock;
  assign lock_ok_c       = 1'b1;
  assign lock_lost_c     = 1'b0;
`endif

  assign restart_c = soft_rst_req | lock_lost_c;

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    gap_d     = gap_q;
    stg_d     = stg_q;
    rst_out_d = rst_out_q;
    ready_d   = ready_q;

    if (restart_c) begin
      state_d   = ST_WAIT;
      wait_d    = '0;
      gap_d     = '0;
      stg_d     = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          gap_d     = '0;
          stg_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
          if (!lock_ok_c) begin
            wait_d = '0;
          end else if (wait_q == WAIT_LAST) begin
            state_d      = ST_RELEASE;
            wait_d       = '0;
            rst_out_d[0] = 1'b0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (stg_q == STG_LAST) begin
              // Last domain has had its full gap; domain is now running.
              state_d   = ST_RUN;
              stg_d     = '0;
              rst_out_d = '0;
              ready_d   = 1'b1;
            end else begin
              stg_d     = stg_q + STG_W'(1);
              rst_out_d = rst_out_q & ~(NUM_DOMAINS'(1) << stg_d);
            end
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end

        ST_RUN: begin
          rst_out_d = '0;
          ready_d   = 1'b1;
        end

        // Illegal encoding recovers through WAIT with everything held in reset.
        default: begin
          state_d   = ST_WAIT;
          wait_d    = '0;
          gap_d     = '0;
          stg_d     = '0;
          rst_out_d = '1;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAIT;
      wait_q    <= '0;
      gap_q     <= '0;
      stg_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      gap_q     <= gap_d;
      stg_q     <= stg_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
    end
  end

  // Enable only while staying in RUN so a restart edge never emits a tick.
  assign tick_en_c = (state_q == ST_RUN) && (state_d == ST_RUN);

  fab_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (tick_en_c),
    .tick(tick)
  );

  assign rst_out   = rst_out_q;
  assign ready     = ready_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fab_clk_rst_sequencer.sv
// Bench for fab_clk_rst_sequencer with STABLE_CYCLES=8, STAGE_GAP=4,
// NUM_DOMAINS=3, TICK_DIV=5. A timeline model (cycles since the sequence
// last started) predicts every output each cycle; directed literal checks
// pin the timeline at the key edges.
module tb_fab_clk_rst_sequencer;

  localparam int S    = 8;
  localparam int G    = 4;
  localparam int ND   = 3;
  localparam int TD   = 5;
`ifdef LOCK_MONITOR_EN
  localparam int LAT  = 2;
`else
  localparam int LAT  = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ccc_lock;
  logic          soft_rst_req;
  logic [ND-1:0] rst_out;
  logic          ready;
  logic          tick;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fab_clk_rst_sequencer #(
    .STABLE_CYCLES(S),
    .NUM_DOMAINS  (ND),
    .STAGE_GAP    (G),
    .TICK_DIV     (TD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ccc_lock    (ccc_lock),
    .soft_rst_req(soft_rst_req),
    .rst_out     (rst_out),
    .ready       (ready),
    .tick        (tick),
    .state_dbg   (state_dbg)
  );

  // ---------------- timeline model ----------------
  int   t_m     = 0;
  bit   valid_m = 1'b0;
  logic [1:0] lsync_m = 2'b00;

  always @(posedge clk) begin
    bit lock_ok_m;
`ifdef LOCK_MONITOR_EN
    lock_ok_m = lsync_m[1];
`else
    lock_ok_m = 1'b1;
`endif
    if (rst) begin
      t_m     = 0;
      lsync_m = 2'b00;
      valid_m = 1'b1;
    end else begin
      // Soft request or missing lock (in any state) restarts the count at 0.
      if (soft_rst_req || !lock_ok_m) t_m = 0;
      else                            t_m = t_m + 1;
      lsync_m = {lsync_m[0], ccc_lock};
    end
  end

  function automatic void model_out(input int t, output logic [ND-1:0] ro,
                                    output logic rd, output logic tk,
                                    output logic [1:0] st);
    logic [ND-1:0] ones;
    int u;
    ones = '1;
    ro = ones; rd = 1'b0; tk = 1'b0; st = 2'd0;
    if (t >= S && t < S + G * ND) begin
      ro = ones << ((t - S) / G + 1);
      st = 2'd1;
    end else if (t >= S + G * ND) begin
      u  = t - S - G * ND;
      ro = '0;
      rd = 1'b1;
      st = 2'd2;
      tk = (u > 0) && (u % TD == 0);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle compare against the model.
  always @(negedge clk) begin
    logic [ND-1:0] ro_e;
    logic rd_e, tk_e;
    logic [1:0] st_e;
    if (valid_m) begin
      model_out(t_m, ro_e, rd_e, tk_e, st_e);
      chk("model.rst_out",   32'(rst_out),   32'(ro_e));
      chk("model.ready",     32'(ready),     32'(rd_e));
      chk("model.tick",      32'(tick),      32'(tk_e));
      chk("model.state_dbg", 32'(state_dbg), 32'(st_e));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Literal timeline after rst falls (edge counts relative to release).
  task automatic power_up_checks(input string tag);
    cyc(7 + LAT); chk({tag, ".hold111"},  32'(rst_out), 32'b111);
    cyc(1);       chk({tag, ".rel0"},     32'(rst_out), 32'b110);
    cyc(3);       chk({tag, ".gap110"},   32'(rst_out), 32'b110);
    cyc(1);       chk({tag, ".rel1"},     32'(rst_out), 32'b100);
    cyc(4);       chk({tag, ".rel2"},     32'(rst_out), 32'b000);
                  chk({tag, ".st_rel"},   32'(state_dbg), 32'd1);
                  chk({tag, ".rdy_lo"},   32'(ready), 32'd0);
    cyc(3);       chk({tag, ".rdy_pre"},  32'(ready), 32'd0);
    cyc(1);       chk({tag, ".rdy_hi"},   32'(ready), 32'd1);
                  chk({tag, ".st_run"},   32'(state_dbg), 32'd2);
    cyc(4);       chk({tag, ".tick_pre"}, 32'(tick), 32'd0);
    cyc(1);       chk({tag, ".tick1"},    32'(tick), 32'd1);
    cyc(1);       chk({tag, ".tick1w"},   32'(tick), 32'd0);
    cyc(4);       chk({tag, ".tick2"},    32'(tick), 32'd1);
  endtask

`ifndef LOCK_MONITOR_EN
  // Lock input must be ignored: tie low for power-up, then toggle.
  bit toggle_en = 1'b0;
  initial begin
    ccc_lock = 1'b0;
    forever begin
      @(negedge clk);
      if (toggle_en) ccc_lock = 1'($urandom_range(0, 1));
    end
  end
`endif

  initial begin
    rst          = 1'b1;
    soft_rst_req = 1'b0;
`ifdef LOCK_MONITOR_EN
    ccc_lock     = 1'b1;
`endif
    cyc(3);
    chk("reset.rst_out", 32'(rst_out),   32'b111);
    chk("reset.ready",   32'(ready),     32'd0);
    chk("reset.tick",    32'(tick),      32'd0);
    chk("reset.state",   32'(state_dbg), 32'd0);
    rst = 1'b0;
    power_up_checks("pwr");

`ifndef LOCK_MONITOR_EN
    toggle_en = 1'b1;
`endif

    // One-cycle soft request on the cycle a tick would otherwise fire.
    cyc(4);
    soft_rst_req = 1'b1;
    cyc(1);
    soft_rst_req = 1'b0;
    chk("soft.rst_out", 32'(rst_out),   32'b111);
    chk("soft.ready",   32'(ready),     32'd0);
    chk("soft.tick",    32'(tick),      32'd0);
    chk("soft.state",   32'(state_dbg), 32'd0);
    cyc(7);  chk("soft.hold111", 32'(rst_out), 32'b111);
    cyc(1);  chk("soft.rel0",    32'(rst_out), 32'b110);
    cyc(11); chk("soft.rdy_pre", 32'(ready),   32'd0);
    cyc(1);  chk("soft.rdy_hi",  32'(ready),   32'd1);

    // Held request: count stays at zero until it drops.
    soft_rst_req = 1'b1;
    cyc(10);
    soft_rst_req = 1'b0;
    chk("hold.state", 32'(state_dbg), 32'd0);
    cyc(7);  chk("hold.hold111", 32'(rst_out), 32'b111);
    cyc(1);  chk("hold.rel0",    32'(rst_out), 32'b110);

    // Hard reset in the middle of RELEASE.
    cyc(5);  chk("mid.rst_out", 32'(rst_out), 32'b100);
    rst = 1'b1;
    cyc(1);
    chk("hard.rst_out", 32'(rst_out),   32'b111);
    chk("hard.ready",   32'(ready),     32'd0);
    chk("hard.state",   32'(state_dbg), 32'd0);
    rst = 1'b0;
    power_up_checks("hard");

`ifdef LOCK_MONITOR_EN
    // Lock drop during the settle count clears it.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(7);
    ccc_lock = 1'b0;
    cyc(4);  chk("lk.wait_state", 32'(state_dbg), 32'd0);
    ccc_lock = 1'b1;
    cyc(9);  chk("lk.hold111", 32'(rst_out), 32'b111);
    cyc(1);  chk("lk.rel0",    32'(rst_out), 32'b110);
    cyc(12); chk("lk.rdy_hi",  32'(ready),   32'd1);
    // Lock loss in RUN restarts three edges later.
    ccc_lock = 1'b0;
    cyc(2);  chk("lk.run_rdy",  32'(ready),   32'd1);
    cyc(1);  chk("lk.loss_rst", 32'(rst_out), 32'b111);
             chk("lk.loss_rdy", 32'(ready),   32'd0);
    ccc_lock = 1'b1;
    cyc(30);
`endif

    cyc(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
